// File: rtl/clb_config_sequencer_if.sv
// Frame handshake between the configuration loader (master) and the sequencer (slave).
// A frame transfers on any rising clk edge where frame_valid and frame_ready are both high.
interface clb_config_sequencer_if #(
   parameter int FRAME_BITS = 37
) ();
   logic [FRAME_BITS-1:0] frame_data;
   logic                  frame_valid;
   logic                  frame_ready;

   modport master (
      output frame_data,
      output frame_valid,
      input  frame_ready
   );

   modport slave (
      input  frame_data,
      input  frame_valid,
      output frame_ready
   );
endinterface

// File: rtl/clb_config_sequencer.sv
// Serialises one parallel frame per CLB onto the shared config bit line, enabling exactly
// one CLB for FRAME_BITS clocks, then releases the fabric into run mode.
module clb_config_sequencer #(
   parameter int NUM_CLB    = 4,
   parameter int FRAME_BITS = 37,
   parameter int IDX_W      = 2,
   parameter int CNT_W      = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   clb_config_sequencer_if.slave frm,
   output logic                bit_out,
   output logic                prgm_b,
   output logic [NUM_CLB-1:0]  clb_prgm_b,
   output logic [IDX_W-1:0]    clb_index,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [1:0]          dbg_state
);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
   localparam logic [1:0] ST_SHIFT      = 2'd2;
   localparam logic [1:0] ST_DONE       = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  prgm_b_q, prgm_b_d;
   logic [NUM_CLB-1:0]    clb_prgm_b_q, clb_prgm_b_d;
   logic                  bit_out_q, bit_out_d;
   logic                  frame_ready_q, frame_ready_d;
   logic [IDX_W-1:0]      clb_index_q, clb_index_d;
   logic                  done_q, done_d;
   logic                  aborted_q, aborted_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;

   logic busy_w;
   logic accept_w;
   logic last_bit_w;
   logic last_clb_w;

   assign busy_w     = (state_q == ST_WAIT_FRAME) || (state_q == ST_SHIFT);
   assign accept_w   = (state_q == ST_WAIT_FRAME) && frm.frame_valid && frame_ready_q;
   assign last_bit_w = (cnt_q == CNT_W'(FRAME_BITS - 1));
   assign last_clb_w = (clb_index_q == IDX_W'(NUM_CLB - 1));

   // bit_out is a registered copy of the shift-register head, so the bit for count k
   // is on the line during the cycle the counter holds k.
   always_comb begin
      state_d       = state_q;
      prgm_b_d      = prgm_b_q;
      clb_prgm_b_d  = clb_prgm_b_q;
      bit_out_d     = bit_out_q;
      frame_ready_d = frame_ready_q;
      clb_index_d   = clb_index_q;
      done_d        = done_q;
      aborted_d     = 1'b0;
      cnt_d         = cnt_q;
      shreg_d       = shreg_q;

      if (busy_w && abort) begin
         state_d       = ST_IDLE;
         prgm_b_d      = 1'b1;
         clb_prgm_b_d  = '0;
         bit_out_d     = 1'b0;
         frame_ready_d = 1'b0;
         clb_index_d   = '0;
         cnt_d         = '0;
         aborted_d     = 1'b1;
         done_d        = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d       = ST_WAIT_FRAME;
                  prgm_b_d      = 1'b0;
                  done_d        = 1'b0;
                  clb_index_d   = '0;
                  cnt_d         = '0;
                  frame_ready_d = 1'b1;
               end
            end

            ST_WAIT_FRAME: begin
               if (accept_w) begin
                  state_d       = ST_SHIFT;
                  frame_ready_d = 1'b0;
                  cnt_d         = '0;
                  bit_out_d     = frm.frame_data[0];
                  shreg_d       = {1'b0, frm.frame_data[FRAME_BITS-1:1]};
                  clb_prgm_b_d  = NUM_CLB'(1) << clb_index_q;
               end
            end

            ST_SHIFT: begin
               if (last_bit_w) begin
                  // Enable drops right after the last bit so the CLB sees exactly FRAME_BITS edges.
                  clb_prgm_b_d = '0;
                  bit_out_d    = 1'b0;
                  cnt_d        = '0;
                  if (last_clb_w) begin
                     state_d  = ST_DONE;
                     prgm_b_d = 1'b1;
                     done_d   = 1'b1;
                  end else begin
                     state_d       = ST_WAIT_FRAME;
                     clb_index_d   = clb_index_q + IDX_W'(1);
                     frame_ready_d = 1'b1;
                  end
               end else begin
                  bit_out_d = shreg_q[0];
                  shreg_d   = {1'b0, shreg_q[FRAME_BITS-1:1]};
                  cnt_d     = cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         prgm_b_q      <= 1'b1;
         clb_prgm_b_q  <= '0;
         bit_out_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         clb_index_q   <= '0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
         cnt_q         <= '0;
         shreg_q       <= '0;
      end else begin
         state_q       <= state_d;
         prgm_b_q      <= prgm_b_d;
         clb_prgm_b_q  <= clb_prgm_b_d;
         bit_out_q     <= bit_out_d;
         frame_ready_q <= frame_ready_d;
         clb_index_q   <= clb_index_d;
         done_q        <= done_d;
         aborted_q     <= aborted_d;
         cnt_q         <= cnt_d;
         shreg_q       <= shreg_d;
      end
   end

   assign frm.frame_ready = frame_ready_q;
   assign bit_out         = bit_out_q;
   assign prgm_b          = prgm_b_q;
   assign clb_prgm_b      = clb_prgm_b_q;
   assign clb_index       = clb_index_q;
   assign busy            = busy_w;
   assign done            = done_q;
   assign aborted         = aborted_q;
   assign dbg_state       = state_q;

endmodule

// File: doc/clb_config_sequencer.md
Name: clb_config_sequencer

Overview:
Bitstream sequencer that programs a chain of CLB configuration shift registers, each holding 16 LUT bits, 1 mux-switch bit and 20 interconnect bits (37 bits total).
- Accepts one parallel 37-bit frame per CLB over a valid/ready handshake.
- Serialises each frame onto the shared config bit line while enabling exactly one CLB for exactly FRAME_BITS clocks.
- Releases the fabric into run mode (prgm_b high, all CLB enables low) after the last CLB.
- Sits between the configuration memory/host loader and the CLB array.

Parameters:
NUM_CLB, 4, number of CLBs programmed per configuration pass
FRAME_BITS, 37, bits shifted per CLB; must match the CLB shift-chain length
IDX_W, 2, width of CLB index counter, equal to clog2(NUM_CLB), minimum 1
CNT_W, 6, width of bit counter, equal to clog2(FRAME_BITS+1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin a configuration pass
abort  input  1  cancel an in-progress pass
frame_data  input  FRAME_BITS  frame for the current CLB
frame_valid  input  1  frame_data valid
frame_ready  output  1  sequencer accepts frame this cycle
bit_out  output  1  serial config bit, drives every CLB bit_in
prgm_b  output  1  global program strobe, low while configuring
clb_prgm_b  output  NUM_CLB  one-hot per-CLB enable; bit k drives CLB k's CLB_prgm_b and CLB_prgm_b_in
clb_index  output  IDX_W  index of the CLB currently being loaded
busy  output  1  pass in progress
done  output  1  high from pass completion until next start/reset
aborted  output  1  single-cycle pulse when abort is taken

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, prgm_b=1, clb_prgm_b=0, bit_out=0, frame_ready=0, clb_index=0, busy=0, done=0, aborted=0, bit counter=0. Reset mid-pass returns to these values on the next edge with no further shifting.
- Frame bit order: frame_data[0] is shifted first and ends in the CLB's LUT bit q0. frame_data[15:0]=LUT q0..q15, [16]=mux switch, [36:17]=interconnect i_q0..i_q19.
- States:
  - IDLE: prgm_b=1, busy=0. start → WAIT_FRAME; prgm_b drops to 0 at the same edge, done clears, clb_index=0.
  - WAIT_FRAME: frame_ready=1, clb_prgm_b=0. When frame_valid&&frame_ready, latch frame_data into the shift register, counter=0 → SHIFT. frame_ready is registered and deasserts at the accepting edge.
  - SHIFT: clb_prgm_b = one-hot(clb_index), bit_out = shreg[0]; shreg shifts right one bit per clock. Exactly FRAME_BITS cycles. Frame accepted at edge T → bits appear on cycles T+1 .. T+FRAME_BITS. After the last bit: if clb_index==NUM_CLB-1 → DONE, else clb_index++ → WAIT_FRAME. clb_prgm_b is 0 in the cycle after the last bit, so the CLB's own counter sees exactly FRAME_BITS enabled edges.
  - DONE: prgm_b=1, clb_prgm_b=0, done=1, busy=0, bit_out=0. start → WAIT_FRAME (new pass, done clears).
- busy=1 in WAIT_FRAME and SHIFT.
- start while busy is ignored.
- abort while busy (takes priority over start and frame acceptance):
  - next state IDLE, prgm_b=1, clb_prgm_b=0, clb_index=0;
  - aborted pulses for 1 cycle; done stays 0.
  - abort in IDLE/DONE is ignored.
- frame_valid outside WAIT_FRAME is ignored; no frame is consumed.
- Back-to-back: if frame_valid is already high when WAIT_FRAME is entered, acceptance occurs in that first WAIT_FRAME cycle. Minimum gap between consecutive CLB shift windows is one cycle.
- NUM_CLB=1: index stays 0 and wraps to nothing; the pass ends after one frame.

Test Plan:
- Reset then start with NUM_CLB=4; frames 37'h0_0000_A5C3, 37'h1F_FFFF_FFFF, 37'h0, 37'h12_3456_789A offered with continuous valid → each CLB's LUT reads back its frame[15:0] (CLB0=16'hA5C3), switch=frame[16], interconnect=frame[36:17]; prgm_b low start→DONE; done=1.
- Check SHIFT timing on CLB0 → clb_prgm_b=4'b0001 for exactly 37 consecutive cycles starting the cycle after acceptance; bit_out sequence equals frame[0]..frame[36].
- Stall frame_valid low for 10 cycles between CLB1 and CLB2 → frame_ready held high, clb_prgm_b=0, bit_out=0 during the stall; loaded contents unaffected.
- abort asserted at bit 20 of CLB2 → next cycle IDLE, prgm_b=1, clb_prgm_b=0, aborted pulse of 1 cycle, done=0. A subsequent start reprograms all four CLBs correctly.
- reset asserted mid-SHIFT of CLB1 → all outputs at reset values next cycle. A start pulse asserted during busy (before reset) → no restart; pass continues unchanged.
- After DONE, a second start with new frames → done clears on the start edge and the second pass completes with new contents.
